dac_frame_scheduler: RTL and testbench
======================================

// Module: dac_frame_scheduler
// PURPOSE
//   Sequences DAC refresh frames for the SPI DAC path. A divider sets the frame rate. Each
//   frame visits every enabled channel in ascending order: fetch a sample from the sample
//   source with a req/ack handshake, then launch one SPI write through the serializer FSM
//   and wait for it to finish. Sits between the sample generator and the SPI serializer.
//   Also owns the DAC clear pulse after reset.
// PARAMETERS
//   DIV      50000  clk cycles per frame tick (>=1)
//   SIZE     12     sample width, bits
//   NCH      4      DAC channels (1..16); channel index width CW = clogb2(NCH), min 1
//   CLR_LEN  16     clk cycles dac_clr is held low after reset release (>=1)
// PORTS
//   clk        in   1     system clock, all logic on rising edge
//   rst        in   1     asynchronous reset, active-low
//   ch_en      in   NCH   channel enable mask, sampled at frame start
//   smp_req    out  1     request a sample for smp_ch
//   smp_ch     out  CW    channel being requested / written
//   smp_ack    in   1     sample valid on smp_data this cycle
//   smp_data   in   SIZE  sample value
//   xfer_start out  1     1-cycle pulse: serializer loads xfer_cmd/addr/data
//   xfer_cmd   out  4     DAC command, constant 4'b0011 (write and update)
//   xfer_addr  out  4     DAC address = smp_ch, zero-extended
//   xfer_data  out  SIZE  latched sample
//   xfer_done  in   1     1-cycle pulse from serializer: transfer complete
//   dac_clr    out  1     DAC clear, active-low
//   busy       out  1     high while a frame is in progress
//   overrun    out  1     sticky: a tick arrived while busy
// BEHAVIOUR
//   Reset (rst=0): state CLR, tick counter 0, clear counter 0. Outputs: smp_req=0, xfer_start=0,
//     xfer_data=0, smp_ch=0, busy=0, overrun=0, dac_clr=0. Reset mid-frame aborts the frame
//     at once. No transfer resumes after reset.
//   Tick divider: counter runs 0..DIV-1 in every state except CLR and wraps to 0.
//     tick is high for 1 cycle when the counter equals DIV-1. With DIV=1, tick is high every cycle.
//   FSM states:
//     CLR   dac_clr=0 for CLR_LEN cycles after reset release, then dac_clr=1 and go to IDLE.
//     IDLE  On tick: latch en_q=ch_en.
//           If en_q==0: stay in IDLE, no bus activity.
//           Otherwise: smp_ch = lowest set bit, busy=1, go to REQ.
//     REQ   smp_req=1 until the cycle of smp_ack, which is the same cycle smp_ack is seen.
//           On smp_ack: xfer_data <= smp_data and go to START. Wait forever if smp_ack
//           never comes. smp_ack outside REQ is ignored.
//     START xfer_start=1 for exactly 1 cycle, then go to WAIT.
//     WAIT  On xfer_done: if a higher enabled bit exists in en_q, set smp_ch to it and go to
//           REQ. Otherwise set busy=0 and go to IDLE. xfer_done outside WAIT is ignored.
//   Latency (ack and done answer in 0 cycles, combinational):
//     tick to smp_req: 1 cycle.
//     smp_ack to xfer_start: 1 cycle.
//     xfer_done to next smp_req (or busy=0): 1 cycle.
//   Changes to ch_en mid-frame have no effect until the next tick.
//   Tick while not in IDLE or CLR: the tick is dropped, overrun is set to 1 and stays 1
//     until reset. The frame in progress continues.
//   A tick in the same cycle the FSM returns to IDLE counts as an overrun, not a frame start.
//   xfer_cmd, xfer_addr and xfer_data are stable from xfer_start until xfer_done.
//   Arithmetic: the tick counter is clogb2(DIV) bits wide, and the compare is against DIV-1.
//     The channel search is a priority encoder on en_q masked to bits above smp_ch.
// TESTING
//   1 Reset: rst=0 then 1, CLR_LEN=16 -> dac_clr low exactly 16 cycles after release,
//     no smp_req before that point.
//   2 DIV=8, ch_en=4'b1111, zero-latency ack/done -> per frame, smp_ch goes 0,1,2,3,
//     4 xfer_start pulses, xfer_addr matches smp_ch; overrun=1 because the frame exceeds 8 cycles.
//   3 DIV=64, ch_en=4'b1010, smp_data=12'hABC then 12'h123 -> writes go to addr 1 then 3
//     with those data; busy drops; overrun=0.
//   4 ch_en=0 at the tick -> no smp_req, no xfer_start, busy stays 0.
//   5 ch_en changed from 4'b0001 to 4'b1000 during REQ -> the current frame writes channel 0
//     only; the next frame writes channel 3 only.
//   6 rst=0 asserted during WAIT -> all outputs at reset values in the same cycle;
//     after CLR, frames restart from the lowest enabled channel.

Source files
------------

// File: rtl/dac_frame_scheduler_if.sv
// Sample-source and serializer bus seen by the DAC frame scheduler.
// The master side is the scheduler; the slave side is the sample generator plus SPI serializer.
interface dac_frame_scheduler_if #(
  parameter int SIZE = 12,
  parameter int NCH  = 4,
  parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]  ch_en;
  logic            smp_req;
  logic [CW-1:0]   smp_ch;
  logic            smp_ack;
  logic [SIZE-1:0] smp_data;
  logic            xfer_start;
  logic [3:0]      xfer_cmd;
  logic [3:0]      xfer_addr;
  logic [SIZE-1:0] xfer_data;
  logic            xfer_done;
  logic            dac_clr;
  logic            busy;
  logic            overrun;

  modport master (
    input  ch_en, smp_ack, smp_data, xfer_done,
    output smp_req, smp_ch, xfer_start, xfer_cmd, xfer_addr, xfer_data,
           dac_clr, busy, overrun
  );

  modport slave (
    output ch_en, smp_ack, smp_data, xfer_done,
    input  smp_req, smp_ch, xfer_start, xfer_cmd, xfer_addr, xfer_data,
           dac_clr, busy, overrun
  );
endinterface

// File: rtl/dac_frame_scheduler.sv
// Per divider tick, fetches a sample for each enabled channel in ascending order and hands
// it to the SPI serializer; also holds dac_clr low for CLR_LEN cycles after reset.
module dac_frame_scheduler #(
  parameter int DIV     = 50000,
  parameter int SIZE    = 12,
  parameter int NCH     = 4,
  parameter int CLR_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dac_frame_scheduler_if.master dif
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [KW-1:0] CLR_LAST  = KW'(CLR_LEN - 1);

  typedef enum logic [2:0] {S_CLR, S_IDLE, S_REQ, S_START, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [KW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [NCH-1:0]  en_q, en_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            overrun_q, overrun_d;
  logic            tick;
  logic            first_vld, next_vld;
  logic [CW-1:0]   first_ch, next_ch;

  // Divider is frozen at zero while the DAC is still being cleared.
  always_comb begin
    tick       = (state_q != S_CLR) && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (state_q == S_CLR || tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end
  end

  // Descending scan so the lowest qualifying channel is the last one written.
  always_comb begin
    first_vld = 1'b0;
    first_ch  = '0;
    next_vld  = 1'b0;
    next_ch   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (dif.ch_en[i]) begin
        first_vld = 1'b1;
        first_ch  = CW'(i);
      end
      if (en_q[i] && (i > int'(ch_q))) begin
        next_vld = 1'b1;
        next_ch  = CW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    en_d      = en_q;
    ch_d      = ch_q;
    data_d    = data_q;
    // A tick landing on the WAIT->IDLE cycle still sees WAIT here, so it is an overrun.
    overrun_d = overrun_q | (tick && (state_q != S_IDLE));
    case (state_q)
      S_CLR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + KW'(1);
        end
      end
      S_IDLE: begin
        if (tick) begin
          en_d = dif.ch_en;
          if (first_vld) begin
            ch_d    = first_ch;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dif.smp_ack) begin
          data_d  = dif.smp_data;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (dif.xfer_done) begin
          if (next_vld) begin
            ch_d    = next_ch;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_CLR;
      tick_cnt_q <= '0;
      clr_cnt_q  <= '0;
      en_q       <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      en_q       <= en_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign dif.smp_req    = (state_q == S_REQ);
  assign dif.smp_ch     = ch_q;
  assign dif.xfer_start = (state_q == S_START);
  assign dif.xfer_cmd   = 4'b0011;
  assign dif.xfer_addr  = 4'(ch_q);
  assign dif.xfer_data  = data_q;
  assign dif.dac_clr    = (state_q != S_CLR);
  assign dif.busy       = (state_q == S_REQ) || (state_q == S_START) || (state_q == S_WAIT);
  assign dif.overrun    = overrun_q;
endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler with DIV=8, CLR_LEN=16, NCH=4, SIZE=12.
module tb_dac_frame_scheduler;
  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  cmd;
    logic [11:0] data;
    logic [1:0]  ch;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ch_en = '0;
  logic        auto_mode = 1'b1;
  logic        man_ack = 1'b0;
  logic        man_done = 1'b0;
  logic [11:0] man_data = '0;
  logic        done_q = 1'b0;
  logic [11:0] data_tbl [4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  wr_t         wlog[$];

  dac_frame_scheduler_if #(.SIZE(12), .NCH(4)) dif ();

  dac_frame_scheduler #(.DIV(8), .SIZE(12), .NCH(4), .CLR_LEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;

  // Auto mode answers ack in the REQ cycle and done in the first WAIT cycle.
  assign dif.ch_en     = ch_en;
  assign dif.smp_ack   = auto_mode ? dif.smp_req : man_ack;
  assign dif.smp_data  = auto_mode ? data_tbl[dif.smp_ch] : man_data;
  assign dif.xfer_done = auto_mode ? done_q : man_done;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    done_q <= dif.xfer_start;
  end

  always @(negedge clk) begin
    if (dif.xfer_start === 1'b1)
      wlog.push_back('{dif.xfer_addr, dif.xfer_cmd, dif.xfer_data, dif.smp_ch, cyc});
  end

  task automatic wait_sig(input int sel, input logic lvl, input int max_cyc,
                          output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max_cyc) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       ok = (dif.smp_req === lvl);
        1:       ok = (dif.busy === lvl);
        default: ok = (dif.dac_clr === lvl);
      endcase
    end
  endtask

  task automatic do_reset;
    bit ok;
    int n;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_sig(2, 1'b1, 40, ok, n);
    checks++;
    if (!ok) begin failures++; $display("FAIL do_reset_clr_timeout: dac_clr never rose"); end
    wlog.delete();
  endtask

  task automatic test_reset;
    int n_clr, n_req;
    bit ok;
    int n;
    rst = 1'b0; ch_en = 4'b0001; auto_mode = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dif.smp_req, dif.xfer_start, dif.busy, dif.overrun, dif.dac_clr} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got req/start/busy/ovr/clr=%b expected 00000",
               {dif.smp_req, dif.xfer_start, dif.busy, dif.overrun, dif.dac_clr});
    end
    checks++;
    if ({dif.smp_ch, dif.xfer_data} !== 14'h0) begin
      failures++;
      $display("FAIL reset_data: got ch=%0h data=%0h expected 0 0", dif.smp_ch, dif.xfer_data);
    end
    rst = 1'b1;
    n_clr = -1; n_req = -1;
    for (int i = 1; i <= 60 && n_req < 0; i++) begin
      @(negedge clk);
      if (n_clr < 0 && dif.dac_clr === 1'b1) n_clr = i;
      if (n_req < 0 && dif.smp_req === 1'b1) n_req = i;
    end
    checks++;
    if (n_clr !== 16) begin failures++; $display("FAIL clr_len: got %0d cycles expected 16", n_clr); end
    checks++;
    if (n_req !== 24) begin failures++; $display("FAIL first_req: got cycle %0d expected 24", n_req); end
    wait_sig(1, 1'b0, 20, ok, n);
    ch_en = 4'b0000;
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_frame_end: busy stuck high"); end
  endtask

  task automatic test_all_channels;
    bit ok;
    int n;
    wlog.delete();
    ch_en = 4'b1111;
    wait_sig(1, 1'b1, 40, ok, n);
    if (ok) wait_sig(1, 1'b0, 40, ok, n);
    ch_en = 4'b0000;
    checks++;
    if (!ok) begin failures++; $display("FAIL all_ch_timeout: busy did not complete a frame"); end
    checks++;
    if (wlog.size() !== 4) begin failures++; $display("FAIL all_ch_count: got %0d writes expected 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].addr !== 4'(i) || wlog[i].ch !== 2'(i) || wlog[i].cmd !== 4'b0011) begin
        failures++;
        $display("FAIL all_ch_addr%0d: got addr=%0h ch=%0h cmd=%0h expected %0h %0h 3",
                 i, wlog[i].addr, wlog[i].ch, wlog[i].cmd, i, i);
      end
      checks++;
      if (wlog[i].data !== data_tbl[i]) begin
        failures++;
        $display("FAIL all_ch_data%0d: got %0h expected %0h", i, wlog[i].data, data_tbl[i]);
      end
      if (i > 0) begin
        checks++;
        if (wlog[i].cyc - wlog[i-1].cyc !== 3) begin
          failures++;
          $display("FAIL all_ch_spacing%0d: got %0d cycles expected 3", i, wlog[i].cyc - wlog[i-1].cyc);
        end
      end
    end
    checks++;
    if (dif.overrun !== 1'b1) begin failures++; $display("FAIL all_ch_overrun: got %b expected 1", dif.overrun); end
  endtask

  task automatic test_two_channels;
    bit ok;
    int n;
    do_reset();
    data_tbl[1] = 12'hABC;
    data_tbl[3] = 12'h123;
    ch_en = 4'b1010;
    wait_sig(1, 1'b1, 40, ok, n);
    if (ok) wait_sig(1, 1'b0, 40, ok, n);
    ch_en = 4'b0000;
    checks++;
    if (!ok) begin failures++; $display("FAIL two_ch_timeout: busy did not complete a frame"); end
    checks++;
    if (wlog.size() !== 2) begin failures++; $display("FAIL two_ch_count: got %0d writes expected 2", wlog.size()); end
    if (wlog.size() == 2) begin
      checks++;
      if (wlog[0].addr !== 4'd1 || wlog[0].data !== 12'hABC) begin
        failures++;
        $display("FAIL two_ch_first: got addr=%0h data=%0h expected 1 abc", wlog[0].addr, wlog[0].data);
      end
      checks++;
      if (wlog[1].addr !== 4'd3 || wlog[1].data !== 12'h123) begin
        failures++;
        $display("FAIL two_ch_second: got addr=%0h data=%0h expected 3 123", wlog[1].addr, wlog[1].data);
      end
    end
    checks++;
    if (dif.overrun !== 1'b0 || dif.busy !== 1'b0) begin
      failures++;
      $display("FAIL two_ch_flags: got overrun=%b busy=%b expected 0 0", dif.overrun, dif.busy);
    end
  endtask

  task automatic test_no_channels;
    int act;
    ch_en = 4'b0000;
    wlog.delete();
    act = 0;
    repeat (30) begin
      @(negedge clk);
      if (dif.smp_req !== 1'b0 || dif.xfer_start !== 1'b0 || dif.busy !== 1'b0) act++;
    end
    checks++;
    if (act !== 0 || wlog.size() !== 0) begin
      failures++;
      $display("FAIL no_ch_activity: got %0d active cycles %0d writes expected 0 0", act, wlog.size());
    end
  endtask

  task automatic test_ch_en_change;
    bit ok;
    int n;
    auto_mode = 1'b0; man_ack = 1'b0; man_done = 1'b0;
    ch_en = 4'b0001;
    wait_sig(0, 1'b1, 20, ok, n);
    checks++;
    if (!ok) begin failures++; $display("FAIL chg_req_timeout: no smp_req"); end
    ch_en = 4'b1000;
    repeat (10) @(negedge clk);
    checks++;
    if (dif.smp_req !== 1'b1 || dif.smp_ch !== 2'd0) begin
      failures++;
      $display("FAIL chg_hold_req: got req=%b ch=%0h expected 1 0", dif.smp_req, dif.smp_ch);
    end
    man_ack = 1'b1; man_data = 12'h5A5;
    @(negedge clk);
    man_ack = 1'b0;
    checks++;
    if (dif.xfer_start !== 1'b1 || dif.xfer_addr !== 4'd0 || dif.xfer_data !== 12'h5A5) begin
      failures++;
      $display("FAIL chg_start: got start=%b addr=%0h data=%0h expected 1 0 5a5",
               dif.xfer_start, dif.xfer_addr, dif.xfer_data);
    end
    @(negedge clk);
    man_ack = 1'b1; man_data = 12'hFFF;
    @(negedge clk);
    man_ack = 1'b0;
    checks++;
    if (dif.xfer_start !== 1'b0 || dif.smp_req !== 1'b0 || dif.busy !== 1'b1 || dif.xfer_data !== 12'h5A5) begin
      failures++;
      $display("FAIL chg_wait_ack_ignored: got start=%b req=%b busy=%b data=%0h expected 0 0 1 5a5",
               dif.xfer_start, dif.smp_req, dif.busy, dif.xfer_data);
    end
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (dif.busy !== 1'b0 || dif.smp_req !== 1'b0 || dif.overrun !== 1'b1) begin
      failures++;
      $display("FAIL chg_end: got busy=%b req=%b overrun=%b expected 0 0 1", dif.busy, dif.smp_req, dif.overrun);
    end
    wlog.delete();
    auto_mode = 1'b1;
    wait_sig(1, 1'b1, 20, ok, n);
    if (ok) wait_sig(1, 1'b0, 20, ok, n);
    ch_en = 4'b0000;
    checks++;
    if (!ok || wlog.size() !== 1) begin
      failures++;
      $display("FAIL chg_next_count: got ok=%b writes=%0d expected 1 1", ok, wlog.size());
    end else begin
      checks++;
      if (wlog[0].addr !== 4'd3 || wlog[0].data !== 12'h123) begin
        failures++;
        $display("FAIL chg_next_write: got addr=%0h data=%0h expected 3 123", wlog[0].addr, wlog[0].data);
      end
    end
  endtask

  task automatic test_reset_in_wait;
    bit ok;
    int n;
    auto_mode = 1'b0; man_ack = 1'b0; man_done = 1'b0;
    ch_en = 4'b0110;
    wait_sig(0, 1'b1, 20, ok, n);
    checks++;
    if (!ok || dif.smp_ch !== 2'd1) begin
      failures++;
      $display("FAIL rw_first_ch: got ok=%b ch=%0h expected 1 1", ok, dif.smp_ch);
    end
    man_ack = 1'b1; man_data = 12'h777;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({dif.smp_req, dif.xfer_start, dif.busy, dif.overrun, dif.dac_clr} !== 5'b0 ||
        {dif.smp_ch, dif.xfer_data} !== 14'h0) begin
      failures++;
      $display("FAIL rw_async_reset: got req/start/busy/ovr/clr=%b ch=%0h data=%0h expected 00000 0 0",
               {dif.smp_req, dif.xfer_start, dif.busy, dif.overrun, dif.dac_clr}, dif.smp_ch, dif.xfer_data);
    end
    wlog.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    auto_mode = 1'b1;
    wait_sig(2, 1'b1, 40, ok, n);
    checks++;
    if (!ok || n !== 16 || wlog.size() !== 0) begin
      failures++;
      $display("FAIL rw_clr: got ok=%b cycles=%0d writes=%0d expected 1 16 0", ok, n, wlog.size());
    end
    wait_sig(1, 1'b1, 20, ok, n);
    if (ok) wait_sig(1, 1'b0, 20, ok, n);
    ch_en = 4'b0000;
    checks++;
    if (!ok || wlog.size() !== 2) begin
      failures++;
      $display("FAIL rw_restart_count: got ok=%b writes=%0d expected 1 2", ok, wlog.size());
    end else begin
      checks++;
      if (wlog[0].addr !== 4'd1 || wlog[0].data !== 12'hABC ||
          wlog[1].addr !== 4'd2 || wlog[1].data !== 12'h303) begin
        failures++;
        $display("FAIL rw_restart_writes: got %0h/%0h %0h/%0h expected 1/abc 2/303",
                 wlog[0].addr, wlog[0].data, wlog[1].addr, wlog[1].data);
      end
    end
  endtask

  initial begin
    data_tbl[0] = 12'h101;
    data_tbl[1] = 12'h202;
    data_tbl[2] = 12'h303;
    data_tbl[3] = 12'h404;
    test_reset();
    test_all_channels();
    test_two_channels();
    test_no_channels();
    test_ch_en_change();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
